prm_oblgc_chk_seq: RTL and testbench

Sequential, parametrised successor to the fixed per-edge PRM obstacle-logic checkers. Instead of one hard-wired sum-of-products per edge, it holds a loadable table of product terms. Each term is a care mask, a value and a target edge ID. The block streams occupied-cell codes through the table and accumulates a sticky per-edge collision mask. It sits between the occupancy-voxel stream and the PRM edge-pruning logic, so all edge checks share one comparator.

---
 rtl/prm_oblgc_chk_seq.sv | 181 ++++++++++++++++++
 tb/tb_prm_oblgc_chk_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prm_oblgc_chk_seq.sv
// prm_oblgc_chk_seq: sequential PRM obstacle-logic checker.
// A loadable table of product terms (care mask, value, edge ID) is swept once
// per occupied-cell code; every matching term sets its edge bit in a sticky
// collision mask that the edge-pruning logic reads when mask_valid pulses.
// Optional build macro: PRM_OBLGC_EARLY_EXIT_EN -- stop scanning once every
// edge is already blocked, since further matches cannot change the result.
module prm_oblgc_chk_seq #(
  parameter int CELL_W     = 15,
  parameter int NUM_EDGES  = 8,
  parameter int TERM_DEPTH = 256,
  parameter int EID_W      = $clog2(NUM_EDGES),
  parameter int TA_W       = $clog2(TERM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 term_wr_en,
  input  logic [TA_W-1:0]      term_wr_addr,
  input  logic [CELL_W-1:0]    term_wr_care,
  input  logic [CELL_W-1:0]    term_wr_val,
  input  logic [EID_W-1:0]     term_wr_edge,
  input  logic [TA_W:0]        cfg_num_terms,
  input  logic                 cell_valid,
  output logic                 cell_ready,
  input  logic [CELL_W-1:0]    cell_data,
  input  logic                 cell_last,
  input  logic                 mask_clr,
  output logic [NUM_EDGES-1:0] edge_mask,
  output logic                 mask_valid,
  output logic                 busy,
  output logic                 cfg_err
);

  localparam int TW = 2 * CELL_W + EID_W;
  localparam logic [TA_W:0] DEPTH_A = (TA_W + 1)'(TERM_DEPTH);
  localparam logic [TA_W:0] ONE_A   = (TA_W + 1)'(1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                 state_reg;
  logic [TW-1:0]          term_mem [TERM_DEPTH];
  logic [TW-1:0]          rd_data_reg;
  logic [TA_W:0]          rd_addr_reg;
  logic [TA_W:0]          num_terms_reg;
  logic [TA_W:0]          num_terms_sat;
  logic [CELL_W-1:0]      cell_reg;
  logic                   last_reg;
  logic                   pipe_valid_reg;
  logic [NUM_EDGES-1:0]   edge_mask_reg;
  logic                   mask_valid_reg;
  logic                   busy_reg;
  logic                   cfg_err_reg;
  logic                   ready_reg;

  logic [CELL_W-1:0]      rd_care;
  logic [CELL_W-1:0]      rd_val;
  logic [EID_W-1:0]       rd_edge;
  logic                   term_match;
  logic                   scan_final;
  logic                   early_exit;
  logic [NUM_EDGES-1:0]   hit_vec;

  // Term count beyond the table size just means "all slots".
  assign num_terms_sat = (cfg_num_terms > DEPTH_A) ? DEPTH_A : cfg_num_terms;

  // Term table: writes locked out while scanning, read data registered.
  always_ff @(posedge clk) begin
    if (term_wr_en && !busy_reg)
      term_mem[term_wr_addr] <= {term_wr_care, term_wr_val, term_wr_edge};
    rd_data_reg <= term_mem[rd_addr_reg[TA_W-1:0]];
  end

  assign rd_care    = rd_data_reg[TW-1 -: CELL_W];
  assign rd_val     = rd_data_reg[EID_W +: CELL_W];
  assign rd_edge    = rd_data_reg[EID_W-1:0];
  assign term_match = (((cell_reg ^ rd_val) & rd_care) == '0);

  // Final compare is the one in flight once every address has been issued.
  assign scan_final = pipe_valid_reg && (rd_addr_reg == num_terms_reg);

`ifdef PRM_OBLGC_EARLY_EXIT_EN
  assign early_exit = &edge_mask_reg;
`else
  assign early_exit = 1'b0;
`endif

  // One decoder lane per edge; IDs with no lane can never set a bit.
  generate
    for (genvar gi = 0; gi < NUM_EDGES; gi++) begin : g_hit
      localparam logic [EID_W-1:0] GI_ID = EID_W'(gi);
      assign hit_vec[gi] = pipe_valid_reg && term_match && (rd_edge == GI_ID);
    end
  endgenerate

  // Control FSM: accept a cell, sweep the term table, report the mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      edge_mask_reg  <= '0;
      mask_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      cfg_err_reg    <= 1'b0;
      ready_reg      <= 1'b0;
      rd_addr_reg    <= '0;
      num_terms_reg  <= '0;
      cell_reg       <= '0;
      last_reg       <= 1'b0;
      pipe_valid_reg <= 1'b0;
    end else begin
      mask_valid_reg <= 1'b0;
      if (term_wr_en && busy_reg)
        cfg_err_reg <= 1'b1;
      if (mask_clr) begin
        // Clear dominates everything, including a same-cycle match or handshake.
        edge_mask_reg  <= '0;
        state_reg      <= IDLE;
        busy_reg       <= 1'b0;
        ready_reg      <= 1'b1;
        pipe_valid_reg <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            ready_reg <= 1'b1;
            if (cell_valid && ready_reg) begin
              cell_reg       <= cell_data;
              last_reg       <= cell_last;
              rd_addr_reg    <= '0;
              num_terms_reg  <= num_terms_sat;
              pipe_valid_reg <= 1'b0;
              if ((num_terms_sat == '0) || early_exit) begin
                // Nothing to scan: the cell is consumed in this cycle.
                if (cell_last) begin
                  state_reg      <= DONE;
                  mask_valid_reg <= 1'b1;
                  ready_reg      <= 1'b0;
                end
              end else begin
                state_reg <= SCAN;
                busy_reg  <= 1'b1;
                ready_reg <= 1'b0;
              end
            end
          end
          SCAN: begin
            edge_mask_reg <= edge_mask_reg | hit_vec;
            if (scan_final || early_exit) begin
              pipe_valid_reg <= 1'b0;
              busy_reg       <= 1'b0;
              if (last_reg) begin
                state_reg      <= DONE;
                mask_valid_reg <= 1'b1;
              end else begin
                state_reg <= IDLE;
                ready_reg <= 1'b1;
              end
            end else begin
              pipe_valid_reg <= (rd_addr_reg < num_terms_reg);
              if (rd_addr_reg < num_terms_reg)
                rd_addr_reg <= rd_addr_reg + ONE_A;
            end
          end
          DONE: begin
            state_reg <= IDLE;
            ready_reg <= 1'b1;
          end
          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            ready_reg <= 1'b1;
          end
        endcase
      end
    end
  end

  assign cell_ready = ready_reg;
  assign edge_mask  = edge_mask_reg;
  assign mask_valid = mask_valid_reg;
  assign busy       = busy_reg;
  assign cfg_err    = cfg_err_reg;

endmodule

// File: tb/tb_prm_oblgc_chk_seq.sv
// Directed bench for prm_oblgc_chk_seq with hand-computed expectations.
module tb_prm_oblgc_chk_seq;

  localparam int CELL_W     = 15;
  localparam int NUM_EDGES  = 8;
  localparam int TERM_DEPTH = 256;
  localparam int EID_W      = 3;
  localparam int TA_W       = 8;

  logic                 clk;
  logic                 rst;
  logic                 term_wr_en;
  logic [TA_W-1:0]      term_wr_addr;
  logic [CELL_W-1:0]    term_wr_care;
  logic [CELL_W-1:0]    term_wr_val;
  logic [EID_W-1:0]     term_wr_edge;
  logic [TA_W:0]        cfg_num_terms;
  logic                 cell_valid;
  logic                 cell_ready;
  logic [CELL_W-1:0]    cell_data;
  logic                 cell_last;
  logic                 mask_clr;
  logic [NUM_EDGES-1:0] edge_mask;
  logic                 mask_valid;
  logic                 busy;
  logic                 cfg_err;

  int vectors = 0;
  int miscompares = 0;

  prm_oblgc_chk_seq #(
    .CELL_W(CELL_W), .NUM_EDGES(NUM_EDGES), .TERM_DEPTH(TERM_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .term_wr_en(term_wr_en), .term_wr_addr(term_wr_addr),
    .term_wr_care(term_wr_care), .term_wr_val(term_wr_val),
    .term_wr_edge(term_wr_edge), .cfg_num_terms(cfg_num_terms),
    .cell_valid(cell_valid), .cell_ready(cell_ready),
    .cell_data(cell_data), .cell_last(cell_last),
    .mask_clr(mask_clr), .edge_mask(edge_mask),
    .mask_valid(mask_valid), .busy(busy), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_term(input int addr, input int care, input int val, input int eid);
    term_wr_en   = 1'b1;
    term_wr_addr = TA_W'(addr);
    term_wr_care = CELL_W'(care);
    term_wr_val  = CELL_W'(val);
    term_wr_edge = EID_W'(eid);
    tick();
    term_wr_en   = 1'b0;
  endtask

  // Offers a cell, waits (bounded) for ready, completes the handshake edge.
  task automatic send_cell(input int data, input logic last);
    int n;
    cell_valid = 1'b1;
    cell_data  = CELL_W'(data);
    cell_last  = last;
    n = 0;
    while (!cell_ready && n < 500) begin
      tick();
      n++;
    end
    check("hs_ready", {31'd0, cell_ready}, 32'd1);
    tick();
    cell_valid = 1'b0;
    cell_last  = 1'b0;
  endtask

  // Called in the cycle after a handshake; returns that cycle's index (1-based).
  task automatic wait_mv(output int cyc);
    cyc = 1;
    while (!mask_valid && cyc < 400) begin
      tick();
      cyc++;
    end
  endtask

  task automatic pulse_clr();
    mask_clr = 1'b1;
    tick();
    mask_clr = 1'b0;
  endtask

  initial begin
    int cyc;
    int pulses;
    rst = 1'b1; term_wr_en = 1'b0; term_wr_addr = '0; term_wr_care = '0;
    term_wr_val = '0; term_wr_edge = '0; cfg_num_terms = '0; cell_valid = 1'b0;
    cell_data = '0; cell_last = 1'b0; mask_clr = 1'b0;
    tick();
    tick();
    check("rst_edge_mask", {24'd0, edge_mask}, 32'h0);
    check("rst_mask_valid", {31'd0, mask_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    check("rst_cell_ready", {31'd0, cell_ready}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: single full-care term, one last cell -> edge 2, pulse on cycle 3
    write_term(0, 'h7FFF, 'h4123, 2);
    cfg_num_terms = 9'd1;
    send_cell('h4123, 1'b1);
    check("t1_ready_scan1", {31'd0, cell_ready}, 32'd0);
    check("t1_busy_scan1", {31'd0, busy}, 32'd1);
    check("t1_mv_scan1", {31'd0, mask_valid}, 32'd0);
    tick();
    check("t1_ready_scan2", {31'd0, cell_ready}, 32'd0);
    check("t1_mv_scan2", {31'd0, mask_valid}, 32'd0);
    tick();
    check("t1_mv_done", {31'd0, mask_valid}, 32'd1);
    check("t1_edge_mask", {24'd0, edge_mask}, 32'h04);
    check("t1_busy_done", {31'd0, busy}, 32'd0);
    tick();
    check("t1_mv_after", {31'd0, mask_valid}, 32'd0);
    check("t1_ready_idle", {31'd0, cell_ready}, 32'd1);

    // 2: two partial-care terms, two cells -> 0x81, one pulse
    pulse_clr();
    check("t2_cleared", {24'd0, edge_mask}, 32'h0);
    write_term(0, 'h000F, 'h0005, 0);
    write_term(1, 'h4000, 'h4000, 7);
    cfg_num_terms = 9'd2;
    pulses = 0;
    send_cell('h0005, 1'b0);
    send_cell('h4000, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (mask_valid) pulses++;
      tick();
    end
    check("t2_pulses", pulses, 32'd1);
    check("t2_edge_mask", {24'd0, edge_mask}, 32'h81);

    // 3: zero terms -> back-to-back acceptance, empty mask, one pulse
    pulse_clr();
    cfg_num_terms = 9'd0;
    cell_valid = 1'b1;
    cell_data = 15'h0001; cell_last = 1'b0;
    check("t3_ready_c1", {31'd0, cell_ready}, 32'd1);
    tick();
    cell_data = 15'h0002;
    check("t3_ready_c2", {31'd0, cell_ready}, 32'd1);
    tick();
    cell_data = 15'h0003; cell_last = 1'b1;
    check("t3_ready_c3", {31'd0, cell_ready}, 32'd1);
    tick();
    cell_valid = 1'b0; cell_last = 1'b0;
    check("t3_mv", {31'd0, mask_valid}, 32'd1);
    check("t3_edge_mask", {24'd0, edge_mask}, 32'h0);
    tick();
    check("t3_mv_after", {31'd0, mask_valid}, 32'd0);

    // 4: write while busy is dropped and flags cfg_err
    pulse_clr();
    write_term(0, 'h7FFF, 'h4123, 2);
    cfg_num_terms = 9'd1;
    send_cell('h0000, 1'b0);
    check("t4_busy", {31'd0, busy}, 32'd1);
    term_wr_en = 1'b1; term_wr_addr = '0; term_wr_care = 15'h7FFF;
    term_wr_val = 15'h0000; term_wr_edge = 3'd5;
    tick();
    term_wr_en = 1'b0;
    check("t4_cfg_err", {31'd0, cfg_err}, 32'd1);
    send_cell('h4123, 1'b1);
    wait_mv(cyc);
    check("t4_mv_cycle", cyc, 32'd3);
    check("t4_edge_mask", {24'd0, edge_mask}, 32'h04);
    check("t4_cfg_err_held", {31'd0, cfg_err}, 32'd1);
    tick();

    // 5: clear on the second scan cycle kills the pulse and the match
    send_cell('h4123, 1'b1);
    check("t5_busy", {31'd0, busy}, 32'd1);
    tick();
    mask_clr = 1'b1;
    tick();
    mask_clr = 1'b0;
    check("t5_edge_mask", {24'd0, edge_mask}, 32'h0);
    check("t5_idle_ready", {31'd0, cell_ready}, 32'd1);
    check("t5_busy_idle", {31'd0, busy}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (mask_valid) pulses++;
      tick();
    end
    check("t5_no_pulse", pulses, 32'd0);
    check("t5_cfg_err_held", {31'd0, cfg_err}, 32'd1);

    // reset clears the sticky error
    rst = 1'b1;
    tick();
    check("rst2_cfg_err", {31'd0, cfg_err}, 32'd0);
    check("rst2_edge_mask", {24'd0, edge_mask}, 32'h0);
    rst = 1'b0;
    tick();

    // 6: 200-term scan; edges all hit by terms 0..7
    for (int i = 0; i < 8; i++) write_term(i, 'h0000, 'h0000, i);
    for (int i = 8; i < 200; i++) write_term(i, 'h7FFF, 'h7FFF, 0);
    cfg_num_terms = 9'd200;
    send_cell('h0000, 1'b1);
    wait_mv(cyc);
`ifdef PRM_OBLGC_EARLY_EXIT_EN
    check("t6_mv_cycle_early", cyc, 32'd11);
`else
    check("t6_mv_cycle_full", cyc, 32'd202);
`endif
    check("t6_edge_mask", {24'd0, edge_mask}, 32'hFF);
    tick();
    check("t6_mv_after", {31'd0, mask_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
